inorder_writeback_unit: RTL and testbench

Consumer end of the unit writeback handshake: collects results from the execution units (multiplier, divider, ALU, load/store), retires them strictly in issue order, and drives the register-file write port. At issue, decode pushes the target unit ID and destination register into an ordering queue. The block pulses `unit_accepted` to the unit at the queue head when that unit reports `done`, which pops the unit's output FIFO. The block then writes the result to the register file one cycle later.

---
 rtl/inorder_writeback_unit_if.sv | 34 +++
 rtl/inorder_writeback_unit.sv | 100 ++++++++++
 tb/tb_inorder_writeback_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/inorder_writeback_unit_if.sv
// Writeback handshake bundle: instruction issue, per-unit done/accepted
// handshake with result buses, and the register-file write port.
interface inorder_writeback_unit_if #(
  parameter int NUM_UNITS   = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int XLEN        = 32
);
  localparam int UIDW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CNTW = $clog2(QUEUE_DEPTH) + 1;

  logic                      issue_valid;
  logic [UIDW-1:0]           issue_unit_id;
  logic [4:0]                issue_rd_addr;
  logic                      issue_ready;
  logic [NUM_UNITS-1:0]      unit_done;
  logic [NUM_UNITS*XLEN-1:0] unit_rd;
  logic [NUM_UNITS-1:0]      unit_accepted;
  logic                      rf_we;
  logic [4:0]                rf_waddr;
  logic [XLEN-1:0]           rf_wdata;
  logic [CNTW-1:0]           inflight_count;

  // Decode/execution-unit side
  modport master (
    output issue_valid, issue_unit_id, issue_rd_addr, unit_done, unit_rd,
    input  issue_ready, unit_accepted, rf_we, rf_waddr, rf_wdata, inflight_count
  );

  // Writeback unit side
  modport slave (
    input  issue_valid, issue_unit_id, issue_rd_addr, unit_done, unit_rd,
    output issue_ready, unit_accepted, rf_we, rf_waddr, rf_wdata, inflight_count
  );
endinterface

// File: rtl/inorder_writeback_unit.sv
// In-order writeback: an ordering queue of {unit_id, rd_addr} records issue
// order; the head entry retires when its unit reports done, pulsing that
// unit's accepted strobe, and the result is written to the register file on
// the following cycle.
module inorder_writeback_unit #(
  parameter int NUM_UNITS   = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int XLEN        = 32
) (
  input logic                    clk,
  input logic                    rst,
  inorder_writeback_unit_if.slave bus
);
  localparam int UIDW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int PTRW = $clog2(QUEUE_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(QUEUE_DEPTH);

  logic [UIDW-1:0] q_uid [QUEUE_DEPTH];
  logic [4:0]      q_rd  [QUEUE_DEPTH];
  logic [PTRW-1:0] head, tail;
  logic [CNTW-1:0] count;

  logic [UIDW-1:0]      head_uid;
  logic [4:0]           head_rd;
  logic                 head_done;
  logic [XLEN-1:0]      head_data;
  logic [NUM_UNITS-1:0] accept_vec;
  logic                 push, pop;

  // Head decode, retire decision and one-hot accept strobe
  always_comb begin
    head_uid   = q_uid[head];
    head_rd    = q_rd[head];
    head_done  = 1'b0;
    head_data  = '0;
    accept_vec = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (head_uid == UIDW'(i)) begin
        head_done = bus.unit_done[i];
        head_data = bus.unit_rd[i*XLEN +: XLEN];
      end
    end
    // count is registered, so an entry pushed this cycle cannot retire yet
    pop  = (count != '0) && head_done;
    push = bus.issue_valid && (count != FULL_CNT);
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      accept_vec[i] = pop && (head_uid == UIDW'(i));
    end
  end

  assign bus.unit_accepted  = accept_vec;
  assign bus.issue_ready    = (count != FULL_CNT);
  assign bus.inflight_count = count;

  // Queue storage: write the issued entry at the tail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        q_uid[i] <= '0;
        q_rd[i]  <= '0;
      end
    end else if (push) begin
      q_uid[tail] <= bus.issue_unit_id;
      q_rd[tail]  <= bus.issue_rd_addr;
    end
  end

  // Pointers and occupancy count; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Register-file write port, one cycle after retire; x0 writes suppressed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      bus.rf_we <= pop && (head_rd != 5'd0);
      if (pop) begin
        bus.rf_waddr <= head_rd;
        bus.rf_wdata <= head_data;
      end
    end
  end
endmodule

// File: tb/tb_inorder_writeback_unit.sv
// Directed bench for inorder_writeback_unit: inputs change on the falling
// edge, outputs are checked 1 time unit later, well away from the rising edge.
module tb_inorder_writeback_unit;
  localparam int NU   = 4;
  localparam int QD   = 4;
  localparam int XL   = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  inorder_writeback_unit_if #(.NUM_UNITS(NU), .QUEUE_DEPTH(QD), .XLEN(XL)) bus ();

  inorder_writeback_unit #(.NUM_UNITS(NU), .QUEUE_DEPTH(QD), .XLEN(XL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input int u, input logic [XL-1:0] v);
    bus.unit_rd[u*XL +: XL] = v;
  endtask

  task automatic issue(input int u, input int rd);
    bus.issue_valid   = 1'b1;
    bus.issue_unit_id = 2'(u);
    bus.issue_rd_addr = 5'(rd);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.issue_valid   = 1'b0;
    bus.issue_unit_id = '0;
    bus.issue_rd_addr = '0;
    bus.unit_done     = '0;
    bus.unit_rd       = '0;

    // Reset values
    #1;
    chk("rst_ready", 32'(bus.issue_ready), 32'd1);
    chk("rst_count", 32'(bus.inflight_count), 32'd0);
    chk("rst_acc",   32'(bus.unit_accepted), 32'd0);
    chk("rst_we",    32'(bus.rf_we), 32'd0);
    chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single op: unit1 rd=5, done 3 cycles after issue
    issue(1, 5);
    tick();
    bus.issue_valid = 1'b0;
    #1 chk("s_count1", 32'(bus.inflight_count), 32'd1);
    chk("s_noacc", 32'(bus.unit_accepted), 32'd0);
    tick();
    tick();
    bus.unit_done = 4'b0010;
    set_rd(1, 32'hDEADBEEF);
    #1 chk("s_acc", 32'(bus.unit_accepted), 32'b0010);
    tick();
    bus.unit_done = '0;
    #1 chk("s_we",    32'(bus.rf_we), 32'd1);
    chk("s_waddr", 32'(bus.rf_waddr), 32'd5);
    chk("s_wdata", bus.rf_wdata, 32'hDEADBEEF);
    chk("s_count0", 32'(bus.inflight_count), 32'd0);
    chk("s_acc0", 32'(bus.unit_accepted), 32'd0);
    tick();
    #1 chk("s_we0", 32'(bus.rf_we), 32'd0);

    // Out-of-order completion: unit2 done early is held behind unit0
    issue(0, 3);
    tick();
    issue(2, 4);
    tick();
    bus.issue_valid = 1'b0;
    bus.unit_done = 4'b0100;
    set_rd(2, 32'h22222222);
    for (int c = 0; c < 4; c++) begin
      #1 chk("o_hold", 32'(bus.unit_accepted), 32'd0);
      tick();
    end
    #1 chk("o_hold_we", 32'(bus.rf_we), 32'd0);
    bus.unit_done = 4'b0101;
    set_rd(0, 32'h11111111);
    #1 chk("o_acc0", 32'(bus.unit_accepted), 32'b0001);
    tick();
    bus.unit_done = 4'b0100;
    #1 chk("o_we3",    32'(bus.rf_we), 32'd1);
    chk("o_waddr3", 32'(bus.rf_waddr), 32'd3);
    chk("o_wdata3", bus.rf_wdata, 32'h11111111);
    chk("o_acc2",   32'(bus.unit_accepted), 32'b0100);
    tick();
    bus.unit_done = '0;
    #1 chk("o_waddr4", 32'(bus.rf_waddr), 32'd4);
    chk("o_wdata4", bus.rf_wdata, 32'h22222222);
    chk("o_count0", 32'(bus.inflight_count), 32'd0);

    // Full queue: 5th issue is dropped
    for (int k = 0; k < 4; k++) begin
      issue(k, 10 + k);
      tick();
    end
    #1 chk("f_ready", 32'(bus.issue_ready), 32'd0);
    chk("f_count", 32'(bus.inflight_count), 32'd4);
    tick();
    #1 chk("f_drop", 32'(bus.inflight_count), 32'd4);
    bus.issue_valid = 1'b0;
    bus.unit_done = 4'b0001;
    set_rd(0, 32'h000000A0);
    #1 chk("f_acc0", 32'(bus.unit_accepted), 32'b0001);
    tick();
    bus.unit_done = 4'b1110;
    #1 chk("f_ready1", 32'(bus.issue_ready), 32'd1);
    chk("f_count3", 32'(bus.inflight_count), 32'd3);
    chk("f_waddr10", 32'(bus.rf_waddr), 32'd10);
    chk("f_acc1", 32'(bus.unit_accepted), 32'b0010);
    tick();
    #1 chk("f_acc2", 32'(bus.unit_accepted), 32'b0100);
    chk("f_waddr11", 32'(bus.rf_waddr), 32'd11);
    tick();
    #1 chk("f_acc3", 32'(bus.unit_accepted), 32'b1000);
    chk("f_waddr12", 32'(bus.rf_waddr), 32'd12);
    tick();
    #1 chk("f_empty", 32'(bus.inflight_count), 32'd0);
    chk("f_acc_none", 32'(bus.unit_accepted), 32'd0);
    chk("f_waddr13", 32'(bus.rf_waddr), 32'd13);
    bus.unit_done = '0;

    // rd=x0: accepted and popped, no register write
    issue(3, 0);
    tick();
    bus.issue_valid = 1'b0;
    bus.unit_done = 4'b1000;
    set_rd(3, 32'h33333333);
    #1 chk("z_acc", 32'(bus.unit_accepted), 32'b1000);
    tick();
    bus.unit_done = '0;
    #1 chk("z_we", 32'(bus.rf_we), 32'd0);
    chk("z_count", 32'(bus.inflight_count), 32'd0);

    // Simultaneous push/pop, 10 ops through depth 4: op j -> unit j%4, rd j+1
    issue(0, 1);
    tick();
    issue(1, 2);
    tick();
    for (int k = 2; k < 12; k++) begin
      int h;
      h = k - 2;
      if (k < 10) issue(k % 4, k + 1);
      else bus.issue_valid = 1'b0;
      bus.unit_done = 4'(1 << (h % 4));
      set_rd(h % 4, 32'h1000 + 32'(h));
      #1 chk("p_acc", 32'(bus.unit_accepted), 32'(1 << (h % 4)));
      if (k < 10) chk("p_count", 32'(bus.inflight_count), 32'd2);
      tick();
      chk("p_waddr", 32'(bus.rf_waddr), 32'(h + 1));
      chk("p_wdata", bus.rf_wdata, 32'h1000 + 32'(h));
    end
    bus.unit_done = '0;
    #1 chk("p_count0", 32'(bus.inflight_count), 32'd0);

    // Reset mid-operation
    issue(1, 7);
    tick();
    issue(2, 8);
    tick();
    issue(0, 9);
    tick();
    issue(3, 6);
    tick();
    bus.issue_valid = 1'b0;
    bus.unit_done = 4'b0010;
    set_rd(1, 32'h77777777);
    tick();
    bus.unit_done = 4'b0100;
    #1 chk("r_pre_count", 32'(bus.inflight_count), 32'd3);
    chk("r_pre_we", 32'(bus.rf_we), 32'd1);
    chk("r_pre_acc", 32'(bus.unit_accepted), 32'b0100);
    #2 rst = 1'b1;
    #1 chk("r_count", 32'(bus.inflight_count), 32'd0);
    chk("r_ready", 32'(bus.issue_ready), 32'd1);
    chk("r_acc",   32'(bus.unit_accepted), 32'd0);
    chk("r_we",    32'(bus.rf_we), 32'd0);
    chk("r_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("r_wdata", bus.rf_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("r_stale", 32'(bus.unit_accepted), 32'd0);
    tick();
    #1 chk("r_stale_cnt", 32'(bus.inflight_count), 32'd0);
    chk("r_stale_we", 32'(bus.rf_we), 32'd0);
    issue(2, 20);
    tick();
    bus.issue_valid = 1'b0;
    #1 chk("r_new_acc", 32'(bus.unit_accepted), 32'b0100);
    tick();
    bus.unit_done = '0;
    #1 chk("r_new_waddr", 32'(bus.rf_waddr), 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
